dpram_block_reader: RTL and testbench
=====================================

# dpram_block_reader

Read-side streamer for the DES accelerator's 64x64 dual-port block RAM. Given a start address and a block count, it issues synchronous reads on one DPRAM port and presents the returned 64-bit words to the DES datapath over a valid/ready handshake. A 2-entry output buffer absorbs the RAM's one-cycle read latency and downstream back-pressure. It is the counterpart of the host-side loader that fills the RAM through the other port.

## Interface
- ADDR_W, 6: DPRAM address width; the RAM holds 2^ADDR_W words.
- DATA_W, 64: word width, one DES block.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_W  first word address.
- blk_count  in  ADDR_W+1  words to read, 0..64; 0 completes immediately.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- mem_en  out  1  DPRAM port enable; high only in cycles that issue a read.
- mem_wr  out  1  DPRAM port write strobe; tied 0, read-only.
- mem_add  out  ADDR_W  DPRAM read address.
- mem_rdata  in  DATA_W  DPRAM read data, valid the cycle after mem_en.
- blk_data  out  DATA_W  output block.
- blk_valid  out  1  blk_data valid.
- blk_ready  in  1  downstream accepts blk_data.
- blk_last  out  1  marks the final block of the request.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 latches start_addr into the address counter and blk_count into the issue and return counters.
  - count 0: go to DONE.
  - otherwise: go to READ.
- start outside IDLE is ignored, with no effect on in-progress counters.
- READ: issue one read per cycle when (buffer occupancy + in-flight read − pop this cycle) < 2.
  - Each read drives mem_en=1 and mem_add=address counter, then increments the address modulo 2^ADDR_W (63 wraps to 0) and decrements the issue counter.
  - When the issue counter reaches 0, go to DRAIN.
- Return path: the cycle after each issued read, mem_rdata is written into the buffer tail. Capture is unconditional; the credit rule guarantees space.
- Output: blk_valid = buffer non-empty and blk_data = buffer head. A pop happens when blk_valid & blk_ready.
  - blk_last=1 when the head is the final word, i.e. return counter == 1.
  - The return counter decrements on each pop.
- DRAIN: no reads issued. After the pop of the blk_last word, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in READ, DRAIN and DONE; busy=0 in IDLE.
- blk_data, blk_valid and blk_last stay stable while blk_valid=1 and blk_ready=0.

## Timing
- Reset values: busy=0, done=0, mem_en=0, mem_wr=0, mem_add=0, blk_valid=0, blk_last=0, blk_data=0. Buffer is emptied, counters cleared, state is IDLE.
- Reset asserted mid-request aborts it immediately. The returning read word is discarded and no done pulse is produced.
- Start sampled at edge E0 gives:
  - first mem_en in the cycle after E0;
  - first blk_valid 2 cycles after the first mem_en.
- With blk_ready held 1, throughput is one block per cycle with no bubbles.
- Request of N blocks with blk_ready=1: the last handshake occurs N+2 cycles after E0, and done pulses the following cycle.
- blk_ready low for K cycles: at most 2 words buffered, and issue stalls. No word is lost or duplicated.
- Pop and capture in the same cycle: occupancy is unchanged.
- blk_count=0: no mem_en, no blk_valid; done pulses 2 cycles after E0.
- blk_count=64: every address is read exactly once, in wrap order.

## Configuration
- DPRAM_RDR_BSWAP_EN:
  - Defined: mem_rdata is byte-reversed at buffer capture, so byte 0 appears on blk_data[63:56] for big-endian DES input. Latency is unchanged.
  - Undefined: words pass through unmodified.

## Test plan
- Reset then idle: all outputs 0. start=0 for 10 cycles gives mem_en=0.
- RAM[i]=64'h1000+i. Start with addr=0, count=8, blk_ready=1: blocks 0x1000..0x1007 appear on 8 consecutive cycles, blk_last on 0x1007, done one cycle later.
- Wrap: addr=62, count=4: mem_add sequence 62, 63, 0, 1, with matching data.
- Back-pressure: count=6 with blk_ready toggling 1,0,0,1 repeating: all 6 words in order, never more than 2 outstanding, blk_data stable during stalls.
- count=0: no reads and no blk_valid; done 2 cycles after start. A second start issued while busy is ignored.
- With DPRAM_RDR_BSWAP_EN defined, RAM[5]=64'h0102030405060708 read out as 64'h0807060504030201.

Source files
------------

// File: rtl/dpram_block_reader.sv
// dpram_block_reader: streams a block of 64-bit words out of one DPRAM port
// onto a valid/ready interface, using a 2-entry buffer that absorbs the
// one-cycle RAM read latency and downstream back-pressure.
// Optional feature macro: DPRAM_RDR_BSWAP_EN (byte-reverse words at capture).
module dpram_block_reader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   blk_count,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_add,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] blk_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              blk_last
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned OCC_W  = 2;
  localparam int unsigned LOAD_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    iss_q, iss_d;
  logic [CNT_W-1:0]    ret_q, ret_d;
  logic                inflight_q, inflight_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [DATA_W-1:0]   buf0_q, buf0_d;
  logic [DATA_W-1:0]   buf1_q, buf1_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                pop_c;
  logic                issue_c;
  logic [LOAD_W-1:0]   load_c;
  logic [DATA_W-1:0]   cap_data_c;

`ifdef DPRAM_RDR_BSWAP_EN
  // Byte reversal so that RAM byte 0 lands in the most significant byte.
  function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DATA_W / 8); i++) begin
      r[8*i +: 8] = w[DATA_W-8-8*i +: 8];
    end
    return r;
  endfunction

  assign cap_data_c = bswap(mem_rdata);
`else
  assign cap_data_c = mem_rdata;
`endif

  // Handshake and read-credit: never let buffered + in-flight words exceed 2.
  assign pop_c   = (occ_q != '0) && blk_ready;
  assign load_c  = LOAD_W'(occ_q) + LOAD_W'(inflight_q);
  assign issue_c = (state_q == S_READ) && (iss_q != '0) &&
                   (load_c < (LOAD_W'(2) + LOAD_W'(pop_c)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (blk_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (issue_c && (iss_q == CNT_W'(1))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop_c && (ret_q == CNT_W'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (done_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status outputs; an empty request holds DONE one extra cycle
  // so its done pulse lands two cycles after the start.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE) && (state_q != S_IDLE);
  end

  // Address/issue/return counters, in-flight flag and 2-entry buffer.
  always_comb begin
    addr_d     = addr_q;
    iss_d      = iss_q;
    ret_d      = ret_q;
    inflight_d = issue_c;
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;

    if ((state_q == S_IDLE) && start) begin
      addr_d = start_addr;
      iss_d  = blk_count;
      ret_d  = blk_count;
    end

    if (issue_c) begin
      addr_d = addr_q + ADDR_W'(1);
      iss_d  = iss_q - CNT_W'(1);
    end

    if (pop_c) begin
      ret_d = ret_q - CNT_W'(1);
    end

    case ({inflight_q, pop_c})
      2'b10: begin
        if (occ_q == '0) begin
          buf0_d = cap_data_c;
        end else begin
          buf1_d = cap_data_c;
        end
        occ_d = occ_q + OCC_W'(1);
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - OCC_W'(1);
      end
      2'b11: begin
        if (occ_q == OCC_W'(2)) begin
          buf0_d = buf1_q;
          buf1_d = cap_data_c;
        end else begin
          buf0_d = cap_data_c;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      iss_q      <= '0;
      ret_q      <= '0;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      iss_q      <= iss_d;
      ret_q      <= ret_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Port mapping; the RAM port is read-only.
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_en    = issue_c;
  assign mem_wr    = 1'b0;
  assign mem_add   = addr_q;
  assign blk_valid = (occ_q != '0);
  assign blk_data  = buf0_q;
  assign blk_last  = (occ_q != '0) && (ret_q == CNT_W'(1));

endmodule

// File: tb/tb_dpram_block_reader.sv
// Directed testbench for dpram_block_reader with a behavioural DPRAM model.
// Honours DPRAM_RDR_BSWAP_EN when the design is built with it.
module tb_dpram_block_reader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 64;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   blk_count;
  logic              busy;
  logic              done;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] blk_data;
  logic              blk_valid;
  logic              blk_ready;
  logic              blk_last;

  logic [DATA_W-1:0] ram [64];

  int checks;
  int failures;

  dpram_block_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .blk_count  (blk_count),
    .busy       (busy),
    .done       (done),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_add    (mem_add),
    .mem_rdata  (mem_rdata),
    .blk_data   (blk_data),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_last   (blk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model: data valid the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= ram[mem_add];
  end

  function automatic logic [DATA_W-1:0] exp_word(input int idx);
    logic [DATA_W-1:0] v;
    logic [DATA_W-1:0] r;
    v = ram[idx % 64];
    r = v;
`ifdef DPRAM_RDR_BSWAP_EN
    for (int i = 0; i < 8; i++) r[8*i +: 8] = v[56-8*i +: 8];
`endif
    return r;
  endfunction

  // Pulse start for one cycle; returns at the start of the cycle after E0.
  task automatic do_start(input int addr, input int cnt);
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = ADDR_W'(addr);
    blk_count  = (ADDR_W+1)'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, mem_en, mem_wr, blk_valid, blk_last} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, mem_en, mem_wr, blk_valid, blk_last});
    end
    checks++;
    if (mem_add !== '0 || blk_data !== '0) begin
      failures++;
      $display("FAIL reset_data got add=%0d data=%h exp=0/0", mem_add, blk_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0 || blk_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet cyc=%0d got en=%b v=%b busy=%b exp=0", c, mem_en, blk_valid, busy);
      end
    end
  endtask

  // Full-rate stream with blk_ready held high; exact cycle-by-cycle timing.
  task automatic test_stream(input string name, input int addr, input int cnt);
    blk_ready = 1'b1;
    do_start(addr, cnt);
    for (int c = 1; c <= cnt + 4; c++) begin
      logic exp_en, exp_v;
      exp_en = (c <= cnt);
      exp_v  = (c >= 3) && (c <= cnt + 2);
      @(negedge clk);
      checks++;
      if (mem_en !== exp_en || (exp_en && mem_add !== ADDR_W'((addr + c - 1) % 64))) begin
        failures++;
        $display("FAIL %s_rd cyc=%0d got en=%b add=%0d exp en=%b add=%0d", name, c, mem_en, mem_add, exp_en, (addr + c - 1) % 64);
      end
      checks++;
      if (blk_valid !== exp_v || (exp_v && (blk_data !== exp_word(addr + c - 3) || blk_last !== (c == cnt + 2)))) begin
        failures++;
        $display("FAIL %s_out cyc=%0d got v=%b d=%h l=%b exp v=%b d=%h l=%b", name, c, blk_valid, blk_data, blk_last, exp_v, exp_word(addr + c - 3), c == cnt + 2);
      end
      checks++;
      if (done !== (c == cnt + 3) || busy !== (c <= cnt + 3) || mem_wr !== 1'b0) begin
        failures++;
        $display("FAIL %s_status cyc=%0d got done=%b busy=%b wr=%b exp done=%b busy=%b wr=0", name, c, done, busy, mem_wr, c == cnt + 3, c <= cnt + 3);
      end
      @(posedge clk); #1;
    end
  endtask

  // blk_ready pattern 1,0,0,1: ordering, buffer bound and stall stability.
  task automatic test_backpressure;
    int n_iss, n_cap, n_pop, buffered;
    logic seen_done, prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic prev_last;
    logic [3:0] pat;
    n_iss = 0; n_cap = 0; n_pop = 0;
    seen_done = 1'b0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    pat = 4'b1001;
    do_start(20, 6);
    for (int c = 1; c <= 60 && !seen_done; c++) begin
      blk_ready = pat[(c - 1) % 4];
      @(negedge clk);
      buffered = n_cap - n_pop;
      checks++;
      if (buffered > 2 || blk_valid !== (buffered > 0)) begin
        failures++;
        $display("FAIL bp_occ cyc=%0d got v=%b exp buffered=%0d (max 2)", c, blk_valid, buffered);
      end
      if (mem_en) begin
        checks++;
        if (mem_add !== ADDR_W'(20 + n_iss) || n_iss >= 6) begin
          failures++;
          $display("FAIL bp_rd cyc=%0d got add=%0d exp add=%0d n=%0d", c, mem_add, 20 + n_iss, n_iss);
        end
      end
      if (prev_stall) begin
        checks++;
        if (blk_valid !== 1'b1 || blk_data !== prev_data || blk_last !== prev_last) begin
          failures++;
          $display("FAIL bp_stable cyc=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", c, blk_valid, blk_data, blk_last, prev_data, prev_last);
        end
      end
      if (blk_valid && blk_ready) begin
        checks++;
        if (blk_data !== exp_word(20 + n_pop) || blk_last !== (n_pop == 5)) begin
          failures++;
          $display("FAIL bp_pop cyc=%0d got d=%h l=%b exp d=%h l=%b", c, blk_data, blk_last, exp_word(20 + n_pop), n_pop == 5);
        end
      end
      if (done) seen_done = 1'b1;
      prev_stall = blk_valid && !blk_ready;
      prev_data  = blk_data;
      prev_last  = blk_last;
      n_cap = n_iss;
      n_iss += int'(mem_en);
      n_pop += int'(blk_valid && blk_ready);
      @(posedge clk); #1;
    end
    checks++;
    if (!seen_done || n_pop != 6 || n_iss != 6) begin
      failures++;
      $display("FAIL bp_total got done=%b pops=%0d reads=%0d exp done=1 pops=6 reads=6", seen_done, n_pop, n_iss);
    end
    blk_ready = 1'b1;
  endtask

  // Empty request, then a start while busy that must be ignored.
  task automatic test_zero_and_ignore;
    int pops;
    logic [DATA_W-1:0] last_d;
    blk_ready = 1'b1;
    do_start(3, 0);
    for (int c = 1; c <= 4; c++) begin
      if (c == 1) begin
        start = 1'b1; start_addr = 6'd9; blk_count = 7'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0 || blk_valid !== 1'b0 || done !== (c == 2) || busy !== (c <= 2)) begin
        failures++;
        $display("FAIL zero cyc=%0d got en=%b v=%b done=%b busy=%b exp en=0 v=0 done=%b busy=%b", c, mem_en, blk_valid, done, busy, c == 2, c <= 2);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    pops = 0; last_d = '0;
    do_start(0, 4);
    for (int c = 1; c <= 10; c++) begin
      start = (c == 2);
      start_addr = 6'd40; blk_count = 7'd10;
      @(negedge clk);
      if (blk_valid && blk_ready) begin
        pops++;
        last_d = blk_data;
      end
      if (mem_en) begin
        checks++;
        if (mem_add > 6'd3) begin
          failures++;
          $display("FAIL ignore_rd cyc=%0d got add=%0d exp 0..3", c, mem_add);
        end
      end
      checks++;
      if (done !== (c == 7)) begin
        failures++;
        $display("FAIL ignore_done cyc=%0d got=%b exp=%b", c, done, c == 7);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (pops != 4 || last_d !== exp_word(3)) begin
      failures++;
      $display("FAIL ignore_total got pops=%0d last=%h exp pops=4 last=%h", pops, last_d, exp_word(3));
    end
  endtask

  // Reset mid-request: outputs clear at once and no completion follows.
  task automatic test_reset_abort;
    blk_ready = 1'b1;
    do_start(30, 8);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_en, blk_valid, blk_last} !== 5'b0) begin
      failures++;
      $display("FAIL abort_now got=%b exp=00000", {busy, done, mem_en, blk_valid, blk_last});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || blk_valid !== 1'b0 || mem_en !== 1'b0) begin
        failures++;
        $display("FAIL abort_after cyc=%0d got done=%b v=%b en=%b exp 0", c, done, blk_valid, mem_en);
      end
      @(posedge clk); #1;
    end
  endtask

  // Single word with a distinctive byte pattern exposes byte ordering.
  task automatic test_bswap;
    logic [DATA_W-1:0] exp_d;
    ram[5] = 64'h0102030405060708;
`ifdef DPRAM_RDR_BSWAP_EN
    exp_d = 64'h0807060504030201;
`else
    exp_d = 64'h0102030405060708;
`endif
    blk_ready = 1'b1;
    do_start(5, 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if (blk_valid !== 1'b1 || blk_last !== 1'b1 || blk_data !== exp_d) begin
          failures++;
          $display("FAIL bswap got v=%b l=%b d=%h exp v=1 l=1 d=%h", blk_valid, blk_last, blk_data, exp_d);
        end
      end
      @(posedge clk); #1;
    end
    ram[5] = 64'h1005;
  endtask

  initial begin
    checks = 0; failures = 0;
    start = 1'b0; start_addr = '0; blk_count = '0; blk_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 64; i++) ram[i] = 64'h1000 + 64'(i);
    test_reset;
    test_stream("basic", 0, 8);
    test_stream("wrap", 62, 4);
    test_stream("full", 10, 64);
    test_backpressure;
    test_zero_and_ignore;
    test_reset_abort;
    test_bswap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
